// File: rtl/tsc_capture_param.sv
// tsc_capture_param: trigger-sample-capture with a DEPTH-entry ring buffer and
// UART-style serial readout of the stored samples, oldest first.
// Ports:
//   clk, reset          clock and synchronous active-high reset.
//   start               arms a capture (IDLE only); trig_level/trig_mode latched then.
//   adc_data/adc_rdy    ADC sample and valid; accepted whenever req && adc_rdy.
//   sbf                 send-buffer request (IDLE only).
//   req                 sample request, high through ARMED and POST.
//   trd                 capture complete (held until next start or reset).
//   cd                  one-cycle pulse when the serial transfer completes.
//   busy                high in any state except IDLE.
//   trigtm              timer value at the trigger sample.
//   sd                  serial data, idles high.
// Optional macro TSC_PARITY_EN: adds an even-parity bit before the stop bit.
module tsc_capture_param #(
  parameter int DW      = 8,
  parameter int DEPTH   = 32,
  parameter int POST_N  = 16,
  parameter int BIT_DIV = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] trig_level,
  input  logic [1:0]    trig_mode,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_rdy,
  input  logic          sbf,
  output logic          req,
  output logic          trd,
  output logic          cd,
  output logic          busy,
  output logic [31:0]   trigtm,
  output logic          sd
);

  localparam int AW = $clog2(DEPTH);
`ifdef TSC_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL  = DW + 2 + PB;             // bits per frame
  localparam int BW  = $clog2(FL);
  localparam int DVW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int PW  = $clog2(POST_N + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_SEND} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   lvl_q, lvl_d;
  logic [1:0]      mode_q, mode_d;
  logic [31:0]     timer_q, timer_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [DW-1:0]   prev_q, prev_d;
  logic            prev_vld_q, prev_vld_d;
  logic [PW-1:0]   post_q, post_d;
  logic            trd_q, trd_d;
  logic            cd_q, cd_d;
  logic [31:0]     trigtm_q, trigtm_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     frames_q, frames_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DVW-1:0]  div_q, div_d;

  logic [DW-1:0]   mem [DEPTH];
  logic            mem_we;

  logic            capturing;
  logic            accept;
  logic            hit;
  logic [DW-1:0]   cur;
  logic [DW-1:0]   cur_sh;
  logic [BW-1:0]   data_idx;
  logic            ser;

  assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
  assign accept    = capturing && adc_rdy;

  // Crossing modes need a previous sample from this capture run.
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      2'd1:    hit = prev_vld_q && (prev_q < lvl_q) && (adc_data >= lvl_q);
      2'd2:    hit = prev_vld_q && (prev_q > lvl_q) && (adc_data <= lvl_q);
      default: hit = (adc_data >= lvl_q);
    endcase
  end

  // Serial bit selection for the frame currently being shifted out.
  always_comb begin
    cur      = mem[rptr_q];
    data_idx = bit_q - BW'(1);
    cur_sh   = cur >> data_idx;
    ser      = 1'b1;
    if (bit_q == '0) begin
      ser = 1'b0;
    end else if (bit_q <= BW'(DW)) begin
      ser = cur_sh[0];
`ifdef TSC_PARITY_EN
    end else if (bit_q == BW'(DW + 1)) begin
      ser = ^cur;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    mode_d     = mode_q;
    timer_d    = timer_q;
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    post_d     = post_q;
    trd_d      = trd_q;
    cd_d       = 1'b0;
    trigtm_d   = trigtm_q;
    rptr_d     = rptr_q;
    frames_d   = frames_q;
    bit_d      = bit_q;
    div_d      = div_q;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lvl_d      = trig_level;
          mode_d     = trig_mode;
          timer_d    = '0;
          wptr_d     = '0;
          fill_d     = '0;
          prev_vld_d = 1'b0;
          trd_d      = 1'b0;
          state_d    = S_ARMED;
        end else if (sbf) begin
          if (fill_q == '0) begin
            cd_d = 1'b1;
          end else begin
            // Oldest entry; a full buffer has fill[AW-1:0]==0 so it starts at wptr.
            rptr_d   = wptr_q - fill_q[AW-1:0];
            frames_d = fill_q;
            bit_d    = '0;
            div_d    = '0;
            state_d  = S_SEND;
          end
        end
      end

      S_ARMED, S_POST: begin
        timer_d = timer_q + 32'd1;
        if (accept) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (fill_q != FULL) fill_d = fill_q + (AW+1)'(1);
          if (state_q == S_ARMED) begin
            prev_d     = adc_data;
            prev_vld_d = 1'b1;
            if (hit) begin
              trigtm_d = timer_q;
              post_d   = '0;
              state_d  = S_POST;
            end
          end else begin
            post_d = post_q + PW'(1);
            if (post_q == PW'(POST_N - 1)) begin
              trd_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end

      S_SEND: begin
        if (div_q == DVW'(BIT_DIV - 1)) begin
          div_d = '0;
          if (bit_q == BW'(FL - 1)) begin
            bit_d    = '0;
            rptr_d   = rptr_q + AW'(1);
            frames_d = frames_q - (AW+1)'(1);
            if (frames_q == (AW+1)'(1)) begin
              cd_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          div_d = div_q + DVW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lvl_q      <= '0;
      mode_q     <= '0;
      timer_q    <= '0;
      wptr_q     <= '0;
      fill_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      post_q     <= '0;
      trd_q      <= 1'b0;
      cd_q       <= 1'b0;
      trigtm_q   <= '0;
      rptr_q     <= '0;
      frames_q   <= '0;
      bit_q      <= '0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      mode_q     <= mode_d;
      timer_q    <= timer_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      post_q     <= post_d;
      trd_q      <= trd_d;
      cd_q       <= cd_d;
      trigtm_q   <= trigtm_d;
      rptr_q     <= rptr_d;
      frames_q   <= frames_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
    end
  end

  // Buffer storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= adc_data;
  end

  assign req    = capturing;
  assign busy   = (state_q != S_IDLE);
  assign trd    = trd_q;
  assign cd     = cd_q;
  assign trigtm = trigtm_q;
  assign sd     = (state_q == S_SEND) ? ser : 1'b1;

endmodule

// File: tb/tb_tsc_capture_param.sv
module tb_tsc_capture_param;

  localparam int DW = 8, DEPTH = 32, POST_N = 16, BIT_DIV = 1;
`ifdef TSC_PARITY_EN
  localparam int FL = DW + 3;
`else
  localparam int FL = DW + 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  trig_level = '0;
  logic [1:0]  trig_mode = '0;
  logic [7:0]  adc_data = '0;
  logic        adc_rdy = 1'b0;
  logic        sbf = 1'b0;
  logic        req, trd, cd, busy, sd;
  logic [31:0] trigtm;

  tsc_capture_param #(.DW(DW), .DEPTH(DEPTH), .POST_N(POST_N), .BIT_DIV(BIT_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .trig_level(trig_level),
    .trig_mode(trig_mode), .adc_data(adc_data), .adc_rdy(adc_rdy), .sbf(sbf),
    .req(req), .trd(trd), .cd(cd), .busy(busy), .trigtm(trigtm), .sd(sd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  cap_d[$];
  bit          cap_r[$];
  logic [7:0]  exp_buf[$];
  logic [15:0] got_frames[$];
  bit          rand_ctl = 1'b0;

  typedef struct packed {
    logic [1:0]        mode;
    logic [7:0]        lvl;
    logic [2:0]        n;
    logic [3:0][7:0]   s;
    logic signed [7:0] exp_idx;  // cycle of the trigger sample, -1 = no trigger
  } row_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; sbf = 1'b0; adc_rdy = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic bit fires(input logic [1:0] md, input bit pv, input logic [7:0] prev,
                               input logic [7:0] s, input logic [7:0] lvl);
    case (md)
      2'd1:    return pv && (prev < lvl) && (s >= lvl);
      2'd2:    return pv && (prev > lvl) && (s <= lvl);
      default: return s >= lvl;
    endcase
  endfunction

  // Frame as the line carries it: bit 0 first; unused upper bits read as idle-high.
  function automatic logic [15:0] expframe(input logic [7:0] v);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = v;
`ifdef TSC_PARITY_EN
    f[9]   = ^v;
`endif
    return f;
  endfunction

  // Model works on the whole planned sample stream: finds the trigger and the
  // completing accept from the capture rules, and keeps the last DEPTH accepted samples.
  task automatic run_capture(input logic [7:0] lvl, input logic [1:0] md);
    int trig = -1, fin = -1, cnt = 0, last;
    bit pv = 1'b0;
    logic [7:0] prev = '0;
    logic [7:0] acc[$];
    for (int c = 0; c < cap_d.size(); c++) begin
      if (cap_r[c]) begin
        acc.push_back(cap_d[c]);
        if (trig < 0) begin
          if (fires(md, pv, prev, cap_d[c], lvl)) trig = c;
          pv = 1'b1; prev = cap_d[c];
        end else begin
          cnt++;
          if (cnt == POST_N) begin fin = c; break; end
        end
      end
    end
    while (acc.size() > DEPTH) void'(acc.pop_front());
    trig_level = lvl; trig_mode = md; start = 1'b1;
    step();
    start = 1'b0;
    last = (fin >= 0) ? fin : cap_d.size() - 1;
    for (int c = 0; c <= last; c++) begin
      chk("req_during_capture", req, 1);
      adc_data = cap_d[c];
      adc_rdy  = cap_r[c];
      if (rand_ctl) begin
        start = 1'($urandom_range(0, 1));
        sbf   = 1'($urandom_range(0, 1));
      end
      step();
    end
    adc_rdy = 1'b0; start = 1'b0; sbf = 1'b0;
    if (fin >= 0) begin
      chk("trd_after_post", trd, 1);
      chk("req_after_post", req, 0);
      chk("busy_after_post", busy, 0);
      chk("trigtm", trigtm, trig);
      exp_buf = acc;
    end else begin
      chk("busy_no_trigger", busy, 1);
      chk("trd_no_trigger", trd, 0);
      do_reset();
      exp_buf.delete();
    end
  endtask

  task automatic do_send();
    logic [15:0] got;
    int n;
    n = exp_buf.size();
    got_frames.delete();
    sbf = 1'b1;
    step();
    sbf = 1'b0;
    for (int f = 0; f < n; f++) begin
      got = '1;
      for (int b = 0; b < FL; b++) begin
        for (int k = 0; k < BIT_DIV; k++) begin
          if (k == 0) got[b] = sd;
          if (rand_ctl) start = 1'($urandom_range(0, 1));
          step();
        end
      end
      start = 1'b0;
      got_frames.push_back(got);
      chk($sformatf("frame%0d", f), got, expframe(exp_buf[f]));
    end
    chk("cd_pulse", cd, 1);
    chk("sd_idle_after_send", sd, 1);
    chk("busy_after_send", busy, 0);
    step();
    chk("cd_clears", cd, 0);
  endtask

  function automatic row_t mk(input logic [1:0] md, input logic [7:0] lvl, input int n,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input int e);
    row_t r;
    r.mode = md; r.lvl = lvl; r.n = 3'(n);
    r.s[0] = a; r.s[1] = b; r.s[2] = c; r.s[3] = d;
    r.exp_idx = 8'(e);
    return r;
  endfunction

  initial begin
    row_t rows[9];
    rows[0] = mk(2'd0,  50, 3,  10,  20,  50, 0,  2);
    rows[1] = mk(2'd1, 100, 3, 150,  50, 120, 0,  2);
    rows[2] = mk(2'd1, 100, 3, 150, 160, 170, 0, -1);
    rows[3] = mk(2'd2, 100, 3,  50, 150, 100, 0,  2);
    rows[4] = mk(2'd2, 100, 3,  50,  60,  70, 0, -1);
    rows[5] = mk(2'd3,   7, 2,   3,   7,   0, 0,  1);
    rows[6] = mk(2'd0,   0, 1,   0,   0,   0, 0,  0);
    rows[7] = mk(2'd1, 100, 2,  99, 100,   0, 0,  1);
    rows[8] = mk(2'd2, 100, 2, 100, 100,   0, 0, -1);

    step(); step();
    reset = 1'b0;
    chk("rst_req", req, 0);
    chk("rst_trd", trd, 0);
    chk("rst_cd", cd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trigtm", trigtm, 0);
    chk("rst_sd", sd, 1);

    // Trigger-rule table.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      trig_level = rows[i].lvl; trig_mode = rows[i].mode; start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < int'(rows[i].n); j++) begin
        adc_data = rows[i].s[j]; adc_rdy = 1'b1;
        step();
      end
      if (rows[i].exp_idx >= 0) begin
        for (int j = 0; j < POST_N; j++) begin
          adc_data = 8'd0; adc_rdy = 1'b1;
          step();
        end
        adc_rdy = 1'b0;
        chk($sformatf("row%0d_trd", i), trd, 1);
        chk($sformatf("row%0d_req", i), req, 0);
        chk($sformatf("row%0d_trigtm", i), trigtm, 32'(rows[i].exp_idx));
      end else begin
        adc_rdy = 1'b0;
        chk($sformatf("row%0d_busy", i), busy, 1);
        chk($sformatf("row%0d_trd", i), trd, 0);
        chk($sformatf("row%0d_req", i), req, 1);
      end
    end

    // Ramp 200.. with level 213: trigger at cycle 13, 30 samples stored.
    do_reset();
    cap_d.delete(); cap_r.delete();
    for (int c = 0; c < 40; c++) begin cap_d.push_back(8'(200 + c)); cap_r.push_back(1'b1); end
    run_capture(8'd213, 2'd0);
    chk("ramp_trigtm_13", trigtm, 13);
    do_send();
    do_send();  // resend gives identical data
    chk("trd_holds_over_send", trd, 1);

    // Wrap: 62 samples accepted, 32 frames, cd 320 cycles after first start bit.
    do_reset();
    cap_d.delete(); cap_r.delete();
    for (int c = 0; c < 80; c++) begin cap_d.push_back(8'(c)); cap_r.push_back(1'b1); end
    run_capture(8'd45, 2'd0);
    do_send();

    // Send with nothing stored.
    do_reset();
    exp_buf.delete();
    do_send();

    // Reset mid-POST aborts; next capture starts from an empty buffer.
    do_reset();
    trig_level = 8'd0; trig_mode = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin adc_data = 8'(c); adc_rdy = 1'b1; step(); end
    reset = 1'b1;
    step();
    chk("midpost_req", req, 0);
    chk("midpost_trd", trd, 0);
    chk("midpost_sd", sd, 1);
    chk("midpost_busy", busy, 0);
    reset = 1'b0; adc_rdy = 1'b0;
    cap_d.delete(); cap_r.delete();
    for (int c = 0; c < 20; c++) begin cap_d.push_back(8'(100 + c)); cap_r.push_back(1'b1); end
    run_capture(8'd0, 2'd0);
    do_send();

    // Sample 0x07: start 0, 1,1,1,0,0,0,0,0, then parity 1 (if enabled), stop 1.
    do_reset();
    cap_d.delete(); cap_r.delete();
    for (int c = 0; c < 20; c++) begin cap_d.push_back(8'h07); cap_r.push_back(1'b1); end
    run_capture(8'd7, 2'd0);
    do_send();
    if (got_frames.size() > 0) chk("frame_0x07", got_frames[0], 16'hFE0E);
    else chk("frame_0x07_present", got_frames.size(), 17);

    // Randomized captures with gaps on adc_rdy and stray start/sbf while busy.
    rand_ctl = 1'b1;
    for (int it = 0; it < 12; it++) begin
      logic [7:0] lvl;
      logic [1:0] md;
      do_reset();
      lvl = 8'($urandom_range(0, 255));
      md  = 2'($urandom_range(0, 3));
      cap_d.delete(); cap_r.delete();
      for (int c = 0; c < 150; c++) begin
        cap_d.push_back(8'($urandom_range(0, 255)));
        cap_r.push_back($urandom_range(0, 3) != 0);
      end
      run_capture(lvl, md);
      do_send();
    end
    rand_ctl = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tsc_capture_param.md
Name: tsc_capture_param

Overview:
Parametrised trigger-sample-capture block, successor to the fixed 8-bit/32-deep TSC.
- Requests samples from the ADC and stores them in a DEPTH-entry ring buffer.
- Detects a trigger with a programmable level and mode, then captures POST_N further samples and timestamps the trigger.
- On request, streams the buffer out oldest-first as UART-style serial frames.
- Sits between the ADC front end and the host serial link.

Parameters:
DW, 8, ADC sample width in bits.
DEPTH, 32, ring buffer entries; power of 2, 4..256.
POST_N, 16, samples captured after the trigger sample; 1..DEPTH-1.
BIT_DIV, 1, clk cycles per serial bit; >=1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  arm capture (sampled in IDLE only)
trig_level  in  DW  trigger threshold, sampled when start is accepted
trig_mode  in  2  0=level >=, 1=rising crossing, 2=falling crossing, 3=treated as 0; sampled with start
adc_data  in  DW  ADC sample
adc_rdy  in  1  ADC sample valid
sbf  in  1  send buffer request (sampled in IDLE only)
req  out  1  request to ADC
trd  out  1  trigger capture complete
cd  out  1  serial transfer complete
busy  out  1  high in any state except IDLE
trigtm  out  32  timer value at the trigger sample
sd  out  1  serial data; idles high

Behaviour:
- Reset: state=IDLE; req=0, trd=0, cd=0, busy=0, trigtm=0, sd=1. Timer, pointers and fill count are cleared. Buffer contents are don't-care. Reset mid-capture or mid-send aborts immediately.
- States: IDLE, ARMED, POST, SEND.
- IDLE, start=1: latch trig_level and trig_mode; clear timer, write pointer, fill count, trd and cd; go to ARMED. req=1 from the next cycle.
- IDLE, start=1 and sbf=1 in the same cycle: start wins.
- Handshake: a sample is accepted on every cycle with req=1 and adc_rdy=1. req stays high for the whole of ARMED and POST. adc_rdy while req=0 is ignored.
- Accepted sample: write at the write pointer; the pointer wraps modulo DEPTH. The fill count saturates at DEPTH.
- Timer: 32-bit, increments every cycle in ARMED and POST, wraps at 2^32.
- Trigger, ARMED only:
  - Mode 0: sample >= level.
  - Mode 1: prev < level and sample >= level.
  - Mode 2: prev > level and sample <= level.
  - prev is the previously accepted sample. The first sample after start cannot fire modes 1 and 2.
  - On trigger: trigtm <= timer in that cycle, post counter=0, go to POST. The trigger sample is stored as a pre-trigger sample.
- POST: each accepted sample increments the post counter. The accept that makes the count POST_N stores that sample; the next cycle has req=0, trd=1 and the state returns to IDLE.
- trd holds until the next accepted start or reset.
- IDLE, sbf=1: go to SEND and clear cd.
  - Frames sent = fill count, oldest-first, starting at (wptr - fill) mod DEPTH.
  - Frame: start bit 0, DW data bits LSB first, stop bit 1. Each bit lasts BIT_DIV cycles.
  - The first start bit appears on sd the cycle after sbf. Frames are back-to-back.
  - After the last stop bit: cd=1 for exactly one cycle, return to IDLE, sd=1.
  - Fill count 0: no frames; cd pulses the cycle after sbf.
  - Send may occur without a trigger (trd=0) and sends whatever is stored. Sending does not alter the buffer or fill count, so repeated sbf resends the same data.
- start and sbf are ignored outside IDLE.

Optional Feature:
TSC_PARITY_EN.
- Defined: an even-parity bit (XOR of the DW data bits) is inserted between the last data bit and the stop bit. Frame length is DW+3 bits.
- Undefined: no parity bit. Frame length is DW+2 bits.

Test Plan:
- DW=8, DEPTH=32, POST_N=16, level=213, mode 0, adc_rdy every cycle, ramp data 200,201,... -> trigger on 213, trigtm=13. Sixteen more samples are stored (214..229), then trd=1 and req=0.
- Mode 1, level=100, first sample 150 then 50,120 -> no trigger on 150; trigger on 120; trigtm equals its timer value.
- Pre-load more than 32 samples (wrap), trigger, then sbf with BIT_DIV=1 -> 32 frames, each 10 bits, oldest stored sample first; cd pulses once 320 cycles after the first start bit.
- sbf after reset with no capture -> sd stays 1; cd pulses the cycle after sbf.
- Reset asserted mid-POST, then start asserted -> req=0, trd=0, sd=1 the cycle after reset; the new capture begins from an empty buffer.
- TSC_PARITY_EN, sample 0x07 -> frame bits 0,1,1,1,0,0,0,0,0,1(parity),1(stop).
